// File: rtl/id_pkg.sv
// Shared types for the instruction-decode pipe: opcodes, register/source
// codes, jump conditions and the control FSM states.
package id_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_OR  = 4'b0010,
        OP_AND = 4'b0011,
        OP_XOR = 4'b0100,
        OP_NOT = 4'b0101,
        OP_ST  = 4'b0110,
        OP_LD  = 4'b0111,
        OP_NOP = 4'b1010,
        OP_JMP = 4'b1111
    } op_code_t;

    // Register-field codes; R0..R3 and DM0..DM3 are families selected by
    // the low two bits, the immediate selector is a single code.
    typedef enum logic [3:0] {
        REG_R0  = 4'b0000,
        REG_R1  = 4'b0001,
        REG_R2  = 4'b0010,
        REG_R3  = 4'b0011,
        REG_IMM = 4'b0100,
        REG_DM0 = 4'b1100,
        REG_DM1 = 4'b1101,
        REG_DM2 = 4'b1110,
        REG_DM3 = 4'b1111
    } reg_code_t;

    // ALU operand source select; NS means "no source".
    typedef enum logic [1:0] {
        SRC_RF = 2'b00,
        SRC_ID = 2'b01,
        SRC_NS = 2'b10,
        SRC_DM = 2'b11
    } aux_src_t;

    // Jump conditions, encoded as the low bits of the register field.
    typedef enum logic [1:0] {
        JC_ALWAYS = 2'b00,
        JC_Z      = 2'b01,
        JC_S      = 2'b10
    } jmp_cond_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_FLAG,
        S_MEM,
        S_OUT
    } state_t;

    function automatic logic cond_met(input jmp_cond_t jc, input logic z, input logic s);
        case (jc)
            JC_ALWAYS: return 1'b1;
            JC_Z:      return z;
            JC_S:      return s;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_dec_core.sv
// Pure combinational instruction decoder: splits the instruction into
// op/reg/imm and produces the control bundle for one instruction.
module id_dec_core
    import id_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int JMP_W  = 5,
    parameter int DM_AW  = 10
) (
    input  logic [8+DATA_W-1:0] instr,
    output logic [3:0]          alu_op,
    output aux_src_t            src,
    output logic [1:0]          rf_addr,
    output logic [DM_AW-1:0]    dm_addr,
    output logic [DATA_W-1:0]   imm,
    output logic [JMP_W-1:0]    jmp_addr,
    output logic                rf_en,
    output logic                dm_we,
    output logic                acc_en,
    output logic                uses_dm,
    output logic                jmp,
    output jmp_cond_t           jmp_cond,
    output logic                illegal
);
    localparam int INSTR_W = 8 + DATA_W;

    logic [3:0]        op;
    logic [3:0]        rc;
    logic [DATA_W+1:0] dm_raw;
    aux_src_t          cls;
    logic              cls_ok;

    assign op       = instr[INSTR_W-1 -: 4];
    assign rc       = instr[DATA_W+3:DATA_W];
    assign imm      = instr[DATA_W-1:0];
    assign jmp_addr = instr[DATA_W-1 -: JMP_W];
    assign rf_addr  = rc[1:0];
    assign dm_raw   = {rc[1:0], imm};

    // Data-memory address is {reg[1:0], imm}, zero-extended or truncated.
    generate
        if (DM_AW > DATA_W + 2) begin : g_dm_ext
            assign dm_addr = {{(DM_AW-DATA_W-2){1'b0}}, dm_raw};
        end else if (DM_AW == DATA_W + 2) begin : g_dm_eq
            assign dm_addr = dm_raw;
        end else begin : g_dm_trunc
            assign dm_addr = dm_raw[DM_AW-1:0];
        end
    endgenerate

    // Classify the register field as an operand source.
    always_comb begin
        cls    = SRC_NS;
        cls_ok = 1'b1;
        if (rc[3:2] == 2'b00)       cls = SRC_RF;
        else if (rc == REG_IMM)     cls = SRC_ID;
        else if (rc[3:2] == 2'b11)  cls = SRC_DM;
        else                        cls_ok = 1'b0;
    end

    // Opcode decode; anything not explicitly legal falls back to a NOP bundle.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        alu_op   = OP_NOP;
        src      = SRC_NS;
        rf_en    = 1'b0;
        dm_we    = 1'b0;
        acc_en   = 1'b0;
        uses_dm  = 1'b0;
        jmp      = 1'b0;
        jmp_cond = JC_ALWAYS;
        illegal  = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_NOT, OP_LD: begin
                if (cls_ok) begin
                    alu_op  = op;
                    src     = cls;
                    acc_en  = 1'b1;
                    uses_dm = (cls == SRC_DM);
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_ST: begin
                if (cls_ok && cls == SRC_RF) begin
                    rf_en = 1'b1;
                end else if (cls_ok && cls == SRC_DM) begin
                    dm_we   = 1'b1;
                    uses_dm = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_JMP: begin
                case (rc)
                    4'b0000: begin jmp = 1'b1; jmp_cond = JC_ALWAYS; end
                    4'b0001: begin jmp = 1'b1; jmp_cond = JC_Z;      end
                    4'b0010: begin jmp = 1'b1; jmp_cond = JC_S;      end
                    default: illegal = 1'b1;
                endcase
            end
            OP_NOP: ;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_pipe.sv
// Instruction-decode pipeline stage: accepts one instruction at a time,
// waits for pending ALU flags or data-memory completion when needed, and
// presents a registered control bundle until the consumer takes it.
module id_pipe
    import id_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int JMP_W  = 5,
    parameter int DM_AW  = 10
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [8+DATA_W-1:0] ID_IN,
    input  logic                ID_VALID,
    output logic                ID_READY,
    input  logic                FR_Z,
    input  logic                FR_S,
    input  logic                FR_VALID,
    input  logic                DM_ACK,
    input  logic                OUT_READY,
    output logic                OUT_VALID,
    output logic                JMP,
    output logic [JMP_W-1:0]    JMP_ADDR,
    output logic                RF_EN,
    output logic [1:0]          RF_ADDR,
    output logic                DM_EN,
    output logic                DM_WE,
    output logic [DM_AW-1:0]    DM_ADDR,
    output logic [1:0]          ALU_MUX_SRC,
    output logic [DATA_W-1:0]   ID_OUT,
    output logic [3:0]          ALU_OP,
    output logic                ACC_EN,
    output logic                ILLEGAL
);
    localparam int INSTR_W = 8 + DATA_W;

    state_t state_q, state_d;

    logic [3:0]        dec_alu_op;
    aux_src_t          dec_src;
    logic [1:0]        dec_rf_addr;
    logic [DM_AW-1:0]  dec_dm_addr;
    logic [DATA_W-1:0] dec_imm;
    logic [JMP_W-1:0]  dec_jmp_addr;
    logic              dec_rf_en, dec_dm_we, dec_acc_en, dec_uses_dm;
    logic              dec_jmp, dec_illegal;
    jmp_cond_t         dec_cond;

    logic [3:0]        alu_op_q;
    aux_src_t          src_q;
    logic [1:0]        rf_addr_q;
    logic [DM_AW-1:0]  dm_addr_q;
    logic [DATA_W-1:0] id_out_q;
    logic [JMP_W-1:0]  jmp_addr_q;
    logic              rf_en_q, dm_we_q, acc_en_q, jmp_q, illegal_q;
    jmp_cond_t         cond_q;

    logic z_q, s_q, flag_pend;
    logic eff_z, eff_s;
    logic accept, out_fire;
    logic idle, out_valid, dm_en;

    id_dec_core #(
        .DATA_W (DATA_W),
        .JMP_W  (JMP_W),
        .DM_AW  (DM_AW)
    ) u_dec (
        .instr    (ID_IN[INSTR_W-1:0]),
        .alu_op   (dec_alu_op),
        .src      (dec_src),
        .rf_addr  (dec_rf_addr),
        .dm_addr  (dec_dm_addr),
        .imm      (dec_imm),
        .jmp_addr (dec_jmp_addr),
        .rf_en    (dec_rf_en),
        .dm_we    (dec_dm_we),
        .acc_en   (dec_acc_en),
        .uses_dm  (dec_uses_dm),
        .jmp      (dec_jmp),
        .jmp_cond (dec_cond),
        .illegal  (dec_illegal)
    );

    // A flag update arriving in the same cycle as acceptance is used directly.
    assign eff_z    = FR_VALID ? FR_Z : z_q;
    assign eff_s    = FR_VALID ? FR_S : s_q;
    assign accept   = ID_VALID & ID_READY;
    assign out_fire = out_valid & OUT_READY;

    // State register; reset drops any in-flight instruction at once.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_d   = state_q;
        idle      = 1'b0;
        out_valid = 1'b0;
        dm_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                idle = 1'b1;
                if (accept) begin
                    if (dec_jmp && dec_cond != JC_ALWAYS && flag_pend && !FR_VALID)
                        state_d = S_WAIT_FLAG;
                    else if (dec_uses_dm)
                        state_d = S_MEM;
                    else
                        state_d = S_OUT;
                end
            end
            S_WAIT_FLAG: if (FR_VALID) state_d = S_OUT;
            S_MEM: begin
                dm_en = 1'b1;
                if (DM_ACK) state_d = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (OUT_READY) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control bundle, captured on acceptance; jump resolved late when waiting.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            alu_op_q   <= OP_NOP;
            src_q      <= SRC_NS;
            rf_addr_q  <= '0;
            dm_addr_q  <= '0;
            id_out_q   <= '0;
            jmp_addr_q <= '0;
            rf_en_q    <= 1'b0;
            dm_we_q    <= 1'b0;
            acc_en_q   <= 1'b0;
            jmp_q      <= 1'b0;
            illegal_q  <= 1'b0;
            cond_q     <= JC_ALWAYS;
        end else if (accept) begin
            alu_op_q   <= dec_alu_op;
            src_q      <= dec_src;
            rf_addr_q  <= dec_rf_addr;
            dm_addr_q  <= dec_dm_addr;
            id_out_q   <= dec_imm;
            jmp_addr_q <= dec_jmp_addr;
            rf_en_q    <= dec_rf_en;
            dm_we_q    <= dec_dm_we;
            acc_en_q   <= dec_acc_en;
            jmp_q      <= dec_jmp & cond_met(dec_cond, eff_z, eff_s);
            illegal_q  <= dec_illegal;
            cond_q     <= dec_cond;
        end else if (state_q == S_WAIT_FLAG && FR_VALID) begin
            jmp_q <= cond_met(cond_q, FR_Z, FR_S);
        end
    end

    // Registered ALU flags and the "flags not yet reported" marker.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            z_q       <= 1'b0;
            s_q       <= 1'b0;
            flag_pend <= 1'b0;
        end else begin
            if (FR_VALID) begin
                z_q <= FR_Z;
                s_q <= FR_S;
            end
            if (out_fire && acc_en_q) flag_pend <= 1'b1;
            else if (FR_VALID)        flag_pend <= 1'b0;
        end
    end

    assign ID_READY    = idle & ~RST;
    assign OUT_VALID   = out_valid;
    assign DM_EN       = dm_en;
    assign DM_WE       = dm_en & dm_we_q;
    assign RF_EN       = out_valid & rf_en_q;
    assign ACC_EN      = out_valid & acc_en_q;
    assign JMP         = out_valid & jmp_q;
    assign ILLEGAL     = out_valid & illegal_q;
    assign JMP_ADDR    = jmp_addr_q;
    assign RF_ADDR     = rf_addr_q;
    assign DM_ADDR     = dm_addr_q;
    assign ALU_MUX_SRC = src_q;
    assign ID_OUT      = id_out_q;
    assign ALU_OP      = alu_op_q;

endmodule

// File: tb/tb_id_pipe.sv
// Directed self-checking bench for id_pipe with hand-computed expectations.
module tb_id_pipe;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] ID_IN;
    logic        ID_VALID, ID_READY;
    logic        FR_Z, FR_S, FR_VALID;
    logic        DM_ACK, OUT_READY;
    logic        OUT_VALID, JMP, RF_EN, DM_EN, DM_WE, ACC_EN, ILLEGAL;
    logic [4:0]  JMP_ADDR;
    logic [1:0]  RF_ADDR, ALU_MUX_SRC;
    logic [9:0]  DM_ADDR;
    logic [7:0]  ID_OUT;
    logic [3:0]  ALU_OP;

    int n_total = 0;
    int n_pass  = 0;

    id_pipe dut (
        .CLK         (CLK),
        .RST         (RST),
        .ID_IN       (ID_IN),
        .ID_VALID    (ID_VALID),
        .ID_READY    (ID_READY),
        .FR_Z        (FR_Z),
        .FR_S        (FR_S),
        .FR_VALID    (FR_VALID),
        .DM_ACK      (DM_ACK),
        .OUT_READY   (OUT_READY),
        .OUT_VALID   (OUT_VALID),
        .JMP         (JMP),
        .JMP_ADDR    (JMP_ADDR),
        .RF_EN       (RF_EN),
        .RF_ADDR     (RF_ADDR),
        .DM_EN       (DM_EN),
        .DM_WE       (DM_WE),
        .DM_ADDR     (DM_ADDR),
        .ALU_MUX_SRC (ALU_MUX_SRC),
        .ID_OUT      (ID_OUT),
        .ALU_OP      (ALU_OP),
        .ACC_EN      (ACC_EN),
        .ILLEGAL     (ILLEGAL)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Present one instruction for a single accepting cycle.
    task automatic issue(input logic [15:0] instr);
        ID_IN    = instr;
        ID_VALID = 1'b1;
        step();
        ID_VALID = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".out_valid"}, OUT_VALID, 0);
        check({tag, ".id_ready"},  ID_READY, 0);
        check({tag, ".dm_en"},     DM_EN, 0);
        check({tag, ".enables"},   {RF_EN, ACC_EN, DM_WE, JMP, ILLEGAL}, 0);
        check({tag, ".addrs"},     {JMP_ADDR, RF_ADDR, DM_ADDR, ID_OUT}, 0);
        check({tag, ".alu_op"},    ALU_OP, 4'hA);
        check({tag, ".alu_src"},   ALU_MUX_SRC, 2'b10);
    endtask

    initial begin
        RST = 1'b1; ID_IN = '0; ID_VALID = 0; FR_Z = 0; FR_S = 0; FR_VALID = 0;
        DM_ACK = 0; OUT_READY = 1;
        #3;
        check_reset_outputs("rst");
        @(posedge CLK); #1; RST = 1'b0; #1;
        check("rst_rel.id_ready", ID_READY, 1);

        // JZ straight after reset: no pending flags, z_q = 0 -> no wait, not taken
        issue(16'hF1A8);
        check("jz0.out_valid", OUT_VALID, 1);
        check("jz0.jmp", JMP, 0);
        check("jz0.jmp_addr", JMP_ADDR, 5'd21);
        step();

        // ADD R2: one-cycle latency, register source
        issue(16'h0200);
        check("add.out_valid", OUT_VALID, 1);
        check("add.alu_op", ALU_OP, 4'h0);
        check("add.src", ALU_MUX_SRC, 2'b00);
        check("add.rf_addr", RF_ADDR, 2);
        check("add.acc_en", ACC_EN, 1);
        check("add.rf_en", RF_EN, 0);
        check("add.id_ready", ID_READY, 0);
        step();
        check("add.idle_ready", ID_READY, 1);
        check("add.idle_valid", OUT_VALID, 0);
        check("add.idle_acc", ACC_EN, 0);
        FR_VALID = 1; FR_Z = 0; FR_S = 0;
        step();
        FR_VALID = 0;

        // LD DM1 imm 0x35: DM_EN exactly three cycles
        issue(16'h7D35);
        check("ld.dm_en1", DM_EN, 1);
        check("ld.dm_addr", DM_ADDR, 10'h135);
        check("ld.dm_we", DM_WE, 0);
        check("ld.valid1", OUT_VALID, 0);
        step();
        check("ld.dm_en2", DM_EN, 1);
        step();
        check("ld.dm_en3", DM_EN, 1);
        DM_ACK = 1;
        step();
        DM_ACK = 0;
        check("ld.dm_en_off", DM_EN, 0);
        check("ld.out_valid", OUT_VALID, 1);
        check("ld.acc_en", ACC_EN, 1);
        check("ld.alu_op", ALU_OP, 4'h7);
        check("ld.src", ALU_MUX_SRC, 2'b11);
        check("ld.id_out", ID_OUT, 8'h35);
        step();

        // LD left flags pending; clear, then SUB sets them pending again
        FR_VALID = 1; step(); FR_VALID = 0;
        issue(16'h1300);
        check("sub.alu_op", ALU_OP, 4'h1);
        check("sub.rf_addr", RF_ADDR, 3);
        step();

        // JZ with flags pending -> WAIT_FLAG until FR_VALID
        issue(16'hF1A8);
        check("jzw.valid1", OUT_VALID, 0);
        check("jzw.ready1", ID_READY, 0);
        step();
        check("jzw.valid2", OUT_VALID, 0);
        check("jzw.jmp_wait", JMP, 0);
        FR_VALID = 1; FR_Z = 1; FR_S = 0;
        step();
        FR_VALID = 0; FR_Z = 0;
        check("jzw.out_valid", OUT_VALID, 1);
        check("jzw.jmp", JMP, 1);
        check("jzw.jmp_addr", JMP_ADDR, 5'd21);
        check("jzw.acc_en", ACC_EN, 0);
        step();

        // Back-pressure: JZ uses registered z_q = 1, consumer stalls 5 cycles
        OUT_READY = 0;
        issue(16'hF1A8);
        for (int i = 0; i < 5; i++) begin
            check("stall.out_valid", OUT_VALID, 1);
            check("stall.jmp", JMP, 1);
            check("stall.bundle", {JMP_ADDR, ALU_OP, ALU_MUX_SRC}, {5'd21, 4'hA, 2'b10});
            check("stall.id_ready", ID_READY, 0);
            step();
        end
        OUT_READY = 1;
        check("stall.last_valid", OUT_VALID, 1);
        step();
        check("stall.released", {OUT_VALID, ID_READY}, 2'b01);

        // JS with s_q = 0: not taken
        issue(16'hF2A8);
        check("js.jmp", {OUT_VALID, JMP}, 2'b10);
        step();

        // ST R1: register write enable
        issue(16'h6100);
        check("st_rf.rf_en", RF_EN, 1);
        check("st_rf.rf_addr", RF_ADDR, 1);
        check("st_rf.acc_en", ACC_EN, 0);
        step();

        // Undefined opcode 1100
        issue(16'hC000);
        check("undef.illegal", ILLEGAL, 1);
        check("undef.enables", {RF_EN, ACC_EN, JMP, DM_EN, DM_WE}, 0);
        check("undef.alu_op", ALU_OP, 4'hA);
        check("undef.src", ALU_MUX_SRC, 2'b10);
        step();

        // ST to immediate is illegal and never touches memory
        issue(16'h6400);
        check("st_imm.illegal", {OUT_VALID, ILLEGAL}, 2'b11);
        check("st_imm.enables", {RF_EN, ACC_EN, JMP, DM_EN, DM_WE}, 0);
        check("st_imm.alu_op", ALU_OP, 4'hA);
        step();
        check("st_imm.cleared", ILLEGAL, 0);

        // Reset in the middle of a memory access
        issue(16'h7E00);
        check("rstmem.dm_en", DM_EN, 1);
        #2; RST = 1'b1; #1;
        check_reset_outputs("rstmem");
        @(posedge CLK); #1; RST = 1'b0; #1;
        check("rstmem.ready", ID_READY, 1);
        step();
        check("rstmem.discard", {OUT_VALID, DM_EN}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_pipe.md
ID_PIPE -- requirements
Module: id_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8: immediate width; instruction width INSTR_W = 8 + DATA_W (localparam).
REQ-002 SHALL have parameter JMP_W, default 5: jump address width, taken from ID_IN[DATA_W-1 -: JMP_W].
REQ-003 SHALL have parameter DM_AW, default 10: data-memory address width.
REQ-004 SHALL have one clock; reset is asynchronous and active-high. Ports: CLK in 1, rising-edge clock; RST in 1, asynchronous active-high reset.
REQ-005 SHALL have ports ID_IN in INSTR_W, instruction; ID_VALID in 1; ID_READY out 1.
REQ-006 SHALL have ports FR_Z in 1, FR_S in 1, ALU zero/sign flags; FR_VALID in 1, flags update strobe.
REQ-007 SHALL have ports DM_ACK in 1, memory completion; OUT_READY in 1, consumer accepts bundle.
REQ-008 SHALL have ports OUT_VALID out 1; JMP out 1; JMP_ADDR out JMP_W; RF_EN out 1; RF_ADDR out 2; DM_EN out 1; DM_WE out 1; DM_ADDR out DM_AW; ALU_MUX_SRC out 2; ID_OUT out DATA_W; ALU_OP out 4; ACC_EN out 1; ILLEGAL out 1.

Function
REQ-009 SHALL decode fields: op = ID_IN[INSTR_W-1 -: 4], reg = ID_IN[DATA_W+3:DATA_W], imm = ID_IN[DATA_W-1:0].
REQ-010 SHALL map reg 00xx to source RF (RF_ADDR = reg[1:0]), 0100 to ID (immediate), 11xx to DM (DM_ADDR = {reg[1:0], imm} zero-extended/truncated to DM_AW); other reg codes ILLEGAL.
REQ-011 ADD/SUB/OR/AND/XOR/NOT/LD SHALL set ALU_OP = op, ALU_MUX_SRC = source, ACC_EN = 1; ID_OUT = imm always.
REQ-012 ST SHALL write accumulator to destination: RF dest -> RF_EN = 1; DM dest -> DM_WE = 1; reg 0100 ILLEGAL.
REQ-013 JMP SHALL use reg as condition: 0000 always, 0001 if Z, 0010 if S, else ILLEGAL; JMP = condition true; JMP_ADDR from imm.
REQ-014 NOP and undefined opcodes SHALL produce ALU_OP = NOP (1010), ALU_MUX_SRC = NS (10), all enables 0; undefined opcodes set ILLEGAL = 1.
REQ-015 FSM states SHALL be IDLE, WAIT_FLAG, MEM, OUT.
REQ-016 ID_READY SHALL be 1 only in IDLE (and not in reset); acceptance = ID_VALID & ID_READY; decoded fields registered on acceptance.
REQ-017 From IDLE on acceptance: conditional JMP with flag_pend = 1 -> WAIT_FLAG; DM source or DM dest -> MEM; else -> OUT (latency 1 cycle to OUT_VALID).
REQ-018 In MEM, DM_EN SHALL be 1 until DM_ACK sampled high, then -> OUT; DM_EN is 0 in all other states.
REQ-019 In OUT, OUT_VALID SHALL be 1 and bundle stable until OUT_READY; on handshake -> IDLE.
REQ-020 RF_EN, ACC_EN, JMP SHALL be 0 whenever OUT_VALID = 0; address/data fields hold last registered value.
REQ-021 Registered flags z_q/s_q SHALL load FR_Z/FR_S when FR_VALID = 1.
REQ-022 flag_pend SHALL set on OUT handshake with ACC_EN = 1, clear on FR_VALID; simultaneous set and clear -> set wins.
REQ-023 In WAIT_FLAG, on FR_VALID = 1 the jump condition SHALL use FR_Z/FR_S of that cycle, then -> OUT; unconditional JMP never waits.
REQ-024 ILLEGAL instructions SHALL pass through OUT with ILLEGAL = 1, no memory access, flag_pend unaffected.

Reset
REQ-025 RST high SHALL immediately force state IDLE, flag_pend = 0, z_q = s_q = 0, ID_READY = 0, all enables/OUT_VALID/JMP/ILLEGAL = 0, addresses/ID_OUT = 0, ALU_OP = NOP, ALU_MUX_SRC = NS.
REQ-026 Reset mid-MEM or mid-OUT SHALL drop DM_EN/OUT_VALID asynchronously and discard the instruction; ID_READY = 1 first rising edge after RST low.

Structure
REQ-027 Package id_pkg SHALL hold OP_CODE_T, REG_CODE_T, AUX_SRC_T, jump-condition codes and the FSM state enum.
REQ-028 Pure decode SHALL live in sub-module id_dec_core (combinational, parameterised identically); id_pipe holds FSM, flags, registers.

Verification
REQ-029 ADD reg R2 (0x0200), OUT_READY = 1 -> next cycle OUT_VALID = 1, ALU_OP = 0000, ALU_MUX_SRC = 00, RF_ADDR = 2, ACC_EN = 1; IDLE after handshake.
REQ-030 LD DM1 imm 0x35 (0x7D35), DM_ACK after 3 cycles -> DM_EN high exactly 3 cycles, DM_ADDR = 0x135, then OUT_VALID with ACC_EN = 1.
REQ-031 SUB then JZ 0xA8 (0xF1A8) before FR_VALID -> WAIT_FLAG; FR_VALID with FR_Z = 1 -> JMP = 1, JMP_ADDR = 21.
REQ-032 OUT_READY held low 5 cycles -> OUT_VALID and bundle stable, ID_READY = 0 throughout.
REQ-033 Opcode 1100 and ST imm (0x6400) -> ILLEGAL = 1, all enables 0, ALU_OP = 1010.
REQ-034 RST asserted during MEM -> DM_EN = 0 same cycle, all outputs at reset values, ID_READY = 1 after release.
